hex_keypad_scanner: RTL



---
 rtl/keypad_pkg.sv | 25 ++
 rtl/level_debouncer.sv | 33 +++
 rtl/hex_keypad_scanner.sv | 119 +++++++++++
 3 files changed

// File: rtl/keypad_pkg.sv
// Shared types and helpers for the hex keypad scanner slice.
package keypad_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic [3:0] COL_ALL  = 4'b1111;
  localparam logic [3:0] COL_NONE = 4'b0000;

  function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
    return {r, c};
  endfunction

  // One-hot column drive for a single column index.
  function automatic logic [3:0] col_select(input logic [1:0] c);
    logic [3:0] v;
    v    = COL_NONE;
    v[c] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/level_debouncer.sv
// Counts consecutive cycles where level equals target_level; stable flags the
// cycle in which the N-th consecutive matching sample is seen.
module level_debouncer #(
  parameter int unsigned N = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic level,
  input  logic target_level,
  output logic stable
);

  localparam int unsigned CW = $clog2(N) + 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  logic [CW-1:0] cnt;
  logic          match;

  assign match  = (level == target_level);
  assign stable = match && (cnt == LAST);

  // Saturating run-length counter; any mismatch restarts the run.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt <= '0;
    end else if (!match) begin
      cnt <= '0;
    end else if (cnt != LAST) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/hex_keypad_scanner.sv
// Column-scanning keypad FSM: debounces a press, walks the columns to locate
// the key, latches its hex code with a one-cycle Valid, then waits for release.
module hex_keypad_scanner
  import keypad_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 8,
  parameter int unsigned SETTLE_CYCLES   = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] Row,
  input  logic       S_Row,
  output logic [3:0] Col,
  output logic [3:0] Code,
  output logic       Valid,
  output logic       Busy
);

  localparam int unsigned SW = $clog2(SETTLE_CYCLES) + 1;
  localparam logic [SW-1:0] SET_LAST = SW'(SETTLE_CYCLES - 1);

  state_t          state;
  logic [1:0]      col_idx;
  logic [SW-1:0]   set_cnt;
  logic [1:0][3:0] row_q;

  logic deb_target_c;
  logic deb_stable_c;
  logic deb_restart_c;

  // Lowest active row wins when several keys share a column.
  function automatic logic [1:0] lowest_row(input logic [3:0] rows);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (rows[i]) r = 2'(i);
    end
    return r;
  endfunction

  // Wait for a press while idle, for a release while holding.
  assign deb_target_c  = (state != HOLD);
  // Restart the run on every state change and throughout the scan.
  assign deb_restart_c = reset || (state == SCAN) || deb_stable_c;

  level_debouncer #(
    .N(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clock       (clock),
    .reset       (deb_restart_c),
    .level       (S_Row),
    .target_level(deb_target_c),
    .stable      (deb_stable_c)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      col_idx <= 2'd0;
      set_cnt <= '0;
      row_q   <= '0;
      Col     <= COL_ALL;
      Code    <= 4'h0;
      Valid   <= 1'b0;
      Busy    <= 1'b0;
    end else begin
      row_q <= {row_q[0], Row};
      Valid <= 1'b0;
      case (state)
        IDLE: begin
          Col  <= COL_ALL;
          Busy <= 1'b0;
          if (deb_stable_c) begin
            state   <= SCAN;
            col_idx <= 2'd0;
            set_cnt <= '0;
            Col     <= col_select(2'd0);
            Busy    <= 1'b1;
          end
        end
        SCAN: begin
          Busy <= 1'b1;
          if (set_cnt != SET_LAST) begin
            set_cnt <= set_cnt + SW'(1);
          end else if (row_q[1] != 4'h0) begin
            Code  <= key_code(lowest_row(row_q[1]), col_idx);
            Valid <= 1'b1;
            state <= HOLD;
            Col   <= COL_ALL;
          end else if (col_idx == 2'd3) begin
            state <= IDLE;
            Col   <= COL_ALL;
            Busy  <= 1'b0;
          end else begin
            col_idx <= col_idx + 2'd1;
            set_cnt <= '0;
            Col     <= col_select(col_idx + 2'd1);
          end
        end
        HOLD: begin
          Col  <= COL_ALL;
          Busy <= 1'b1;
          if (deb_stable_c) begin
            state <= IDLE;
            Busy  <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          col_idx <= 2'd0;
          set_cnt <= '0;
          Col     <= COL_ALL;
          Busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
